// File: rtl/ab_policy_monitor.sv
// ab_policy_monitor
//   Re-checks the A->B response policy on the enforcer's final stream and
//   keeps saturating edit/recovery statistics for debug readback.
//
// Ports
//   clk, reset       : single clock; reset is synchronous and active-high
//   A_ctp_in/B_ctp_in       : plant-proposed values (before the enforcer)
//   A_ctp_final/B_ctp_final : enforcer outputs, the monitored stream
//   recovery_ref     : enforcer recovery reference, nonzero = recovery tick
//   clear            : synchronous clear of FSM, violation and counters
//   mon_state        : 0 IDLE, 1 WAIT, 2 VIOL
//   violation        : high exactly while in VIOL
//   violation_code   : 0 none, 1 B w/o A, 2 A while pending / A&B, 3 deadline
//   wait_count       : ticks since the pending A
//   edit_pulse       : registered "enforcer edited A or B" of the sampled tick
//   edit_count       : saturating count of edit ticks
//   recovery_count   : saturating count of recovery ticks
module ab_policy_monitor #(
  parameter int MAX_WAIT = 5,
  parameter int WAIT_W   = 4,
  parameter int COUNT_W  = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               A_ctp_in,
  input  logic               B_ctp_in,
  input  logic               A_ctp_final,
  input  logic               B_ctp_final,
  input  logic [1:0]         recovery_ref,
  input  logic               clear,
  output logic [1:0]         mon_state,
  output logic               violation,
  output logic [1:0]         violation_code,
  output logic [WAIT_W-1:0]  wait_count,
  output logic               edit_pulse,
  output logic [COUNT_W-1:0] edit_count,
  output logic [COUNT_W-1:0] recovery_count
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_VIOL = 2'd2;

  localparam logic [1:0] C_NONE     = 2'd0;
  localparam logic [1:0] C_B_NO_A   = 2'd1;
  localparam logic [1:0] C_A_REPEAT = 2'd2;
  localparam logic [1:0] C_DEADLINE = 2'd3;

  // Last legal wait value; B may still arrive on the tick this is reached.
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

  logic              edit;
  logic [1:0]        nxt_state;
  logic [1:0]        nxt_code;
  logic [WAIT_W-1:0] nxt_wc;

  assign edit = (A_ctp_in ^ A_ctp_final) | (B_ctp_in ^ B_ctp_final);

  always_comb begin
    nxt_state = mon_state;
    nxt_code  = violation_code;
    nxt_wc    = wait_count;
    case (mon_state)
      S_IDLE: begin
        if (A_ctp_final && B_ctp_final) begin
          nxt_state = S_VIOL;
          nxt_code  = C_A_REPEAT;
        end else if (A_ctp_final) begin
          nxt_state = S_WAIT;
          nxt_wc    = '0;
        end else if (B_ctp_final) begin
          nxt_state = S_VIOL;
          nxt_code  = C_B_NO_A;
        end
      end
      S_WAIT: begin
        // A wins over a simultaneous B: a fresh A while one is pending is illegal.
        if (A_ctp_final) begin
          nxt_state = S_VIOL;
          nxt_code  = C_A_REPEAT;
        end else if (B_ctp_final) begin
          nxt_state = S_IDLE;
          nxt_wc    = '0;
        end else if (wait_count == WAIT_LAST) begin
          nxt_state = S_VIOL;
          nxt_code  = C_DEADLINE;
        end else begin
          nxt_wc = wait_count + 1'b1;
        end
      end
      S_VIOL: ; // absorbing; code and wait_count frozen
      default: begin
        nxt_state = S_IDLE;
        nxt_code  = C_NONE;
        nxt_wc    = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      mon_state      <= S_IDLE;
      violation      <= 1'b0;
      violation_code <= C_NONE;
      wait_count     <= '0;
      edit_pulse     <= 1'b0;
      edit_count     <= '0;
      recovery_count <= '0;
    end else begin
      mon_state      <= nxt_state;
      violation      <= (nxt_state == S_VIOL);
      violation_code <= nxt_code;
      wait_count     <= nxt_wc;
      edit_pulse     <= edit;
      // Statistics run in every state and hold at all-ones.
      if (edit && (edit_count != '1))
        edit_count <= edit_count + 1'b1;
      if ((recovery_ref != 2'd0) && (recovery_count != '1))
        recovery_count <= recovery_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_ab_policy_monitor.sv
module tb_ab_policy_monitor;

  localparam int MAX_WAIT = 5;
  localparam int WAIT_W   = 4;
  localparam int COUNT_W  = 4;
  localparam int CMAX     = (1 << COUNT_W) - 1;

  logic               clk = 1'b0;
  logic               reset = 1'b0, clear = 1'b0;
  logic               a_in = 1'b0, b_in = 1'b0, a_f = 1'b0, b_f = 1'b0;
  logic [1:0]         rec = 2'd0;
  logic [1:0]         mon_state, violation_code;
  logic               violation, edit_pulse;
  logic [WAIT_W-1:0]  wait_count;
  logic [COUNT_W-1:0] edit_count, recovery_count;

  int vectors = 0;
  int miscompares = 0;

  ab_policy_monitor #(.MAX_WAIT(MAX_WAIT), .WAIT_W(WAIT_W), .COUNT_W(COUNT_W)) dut (
    .clk(clk), .reset(reset),
    .A_ctp_in(a_in), .B_ctp_in(b_in), .A_ctp_final(a_f), .B_ctp_final(b_f),
    .recovery_ref(rec), .clear(clear),
    .mon_state(mon_state), .violation(violation), .violation_code(violation_code),
    .wait_count(wait_count), .edit_pulse(edit_pulse),
    .edit_count(edit_count), .recovery_count(recovery_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, clr, ai, bi, af, bf;
    logic [1:0] rc;
    logic [1:0] st, code;
    logic [3:0] wc;
    logic       pulse;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, c, ai, bi, af, bf, input logic [1:0] rc,
                     input logic [1:0] st, code, input logic [3:0] wc, input logic pulse);
    vec_t v;
    v.rst = r; v.clr = c; v.ai = ai; v.bi = bi; v.af = af; v.bf = bf; v.rc = rc;
    v.st = st; v.code = code; v.wc = wc; v.pulse = pulse;
    tbl.push_back(v);
  endtask

  // Plain stimulus shortcut: proposed == final, no recovery.
  task automatic addp(input logic r, c, a, b, input logic [1:0] st, code, input logic [3:0] wc);
    add(r, c, a, b, a, b, 2'd0, st, code, wc, 1'b0);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Inputs change only on the falling edge; outputs are read on the next one.
  task automatic tick(input logic r, c, ai, bi, af, bf, input logic [1:0] rc);
    reset = r; clear = c; a_in = ai; b_in = bi; a_f = af; b_f = bf; rec = rc;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_fsm(input string tag, input logic [1:0] st, code, input logic [3:0] wc);
    chk({tag, ".mon_state"}, 32'(mon_state), 32'(st));
    chk({tag, ".violation"}, 32'(violation), 32'(st == 2'd2));
    chk({tag, ".code"},      32'(violation_code), 32'(code));
    chk({tag, ".wait_count"},32'(wait_count), 32'(wc));
  endtask

  // Reference model: tracks the tick number of the pending A and decides from
  // the elapsed distance, rather than stepping a wait counter.
  int        m_t, m_atick, m_wc, m_edits, m_recs, m_code;
  bit        m_pending, m_pulse;

  task automatic model_step(input bit r, c, ai, bi, af, bf, input int rc);
    if (r || c) begin
      m_code = 0; m_pending = 0; m_wc = 0; m_edits = 0; m_recs = 0; m_pulse = 0;
    end else begin
      m_pulse = (ai != af) || (bi != bf);
      if (m_pulse) m_edits++;
      if (rc != 0) m_recs++;
      if (m_code == 0) begin
        if (m_pending) begin
          if (af) m_code = 2;
          else if (bf) begin m_pending = 0; m_wc = 0; end
          else if (m_t - m_atick == MAX_WAIT) m_code = 3;
          else m_wc = m_t - m_atick;
        end else begin
          if (af && bf) m_code = 2;
          else if (af) begin m_pending = 1; m_atick = m_t; m_wc = 0; end
          else if (bf) m_code = 1;
        end
      end
    end
    m_t++;
  endtask

  initial begin
    // Directed table, MAX_WAIT = 5
    addp(1,0,0,0, 0,0,0);                              // reset state
    addp(0,0,1,0, 1,0,0);                              // A at tick 0
    addp(0,0,0,0, 1,0,1);
    addp(0,0,0,0, 1,0,2);
    addp(0,0,0,1, 0,0,0);                              // B at tick 3 -> IDLE
    addp(0,0,1,0, 1,0,0);                              // A, then no B
    for (int i = 1; i <= 4; i++) addp(0,0,0,0, 1,0,4'(i));
    addp(0,0,0,0, 2,3,4);                              // deadline miss
    addp(0,0,0,1, 2,3,4);                              // VIOL absorbing
    addp(0,1,1,0, 0,0,0);                              // clear with A=1
    addp(0,0,0,1, 2,1,0);                              // B in IDLE
    addp(0,1,0,0, 0,0,0);
    addp(0,0,1,0, 1,0,0);
    addp(0,0,1,1, 2,2,0);                              // A&B in WAIT
    addp(0,1,0,0, 0,0,0);
    addp(0,0,1,1, 2,2,0);                              // A&B in IDLE
    addp(0,1,0,0, 0,0,0);
    addp(0,0,1,0, 1,0,0);                              // B at t+MAX_WAIT legal
    for (int i = 1; i <= 4; i++) addp(0,0,0,0, 1,0,4'(i));
    addp(0,0,0,1, 0,0,0);
    addp(0,0,1,0, 1,0,0);                              // back-to-back A,B,A,B
    addp(0,0,0,1, 0,0,0);
    addp(0,0,1,0, 1,0,0);
    addp(0,0,0,1, 0,0,0);
    addp(0,0,1,0, 1,0,0);                              // reset mid-WAIT
    addp(0,0,0,0, 1,0,1);
    addp(1,0,0,0, 0,0,0);
    addp(0,0,0,1, 2,1,0);                              // pending A forgotten
    addp(1,0,0,0, 0,0,0);
    add(0,0,1,0,0,0, 2'd0, 0,0,0, 1);                  // edit suppresses A
    add(0,0,0,0,0,0, 2'd0, 0,0,0, 0);
    add(0,0,0,1,0,0, 2'd0, 0,0,0, 1);                  // edit suppresses B
    add(0,0,1,1,1,0, 2'd0, 1,0,0, 1);                  // edited B, A passes

    foreach (tbl[i]) begin
      tick(tbl[i].rst, tbl[i].clr, tbl[i].ai, tbl[i].bi, tbl[i].af, tbl[i].bf, tbl[i].rc);
      chk_fsm($sformatf("vec%0d", i), tbl[i].st, tbl[i].code, tbl[i].wc);
      chk($sformatf("vec%0d.edit_pulse", i), 32'(edit_pulse), 32'(tbl[i].pulse));
    end

    // Saturation: 20 edit+recovery ticks, counters stop at all-ones.
    tick(1,0,0,0,0,0,2'd0);
    chk("sat.reset_edit", 32'(edit_count), 32'd0);
    chk("sat.reset_rec", 32'(recovery_count), 32'd0);
    for (int i = 1; i <= 20; i++) begin
      tick(0,0,1,0,0,0,2'd2);
      chk($sformatf("sat%0d.edit_pulse", i), 32'(edit_pulse), 32'd1);
      chk($sformatf("sat%0d.edit_count", i), 32'(edit_count), 32'(i < CMAX ? i : CMAX));
      chk($sformatf("sat%0d.rec_count", i), 32'(recovery_count), 32'(i < CMAX ? i : CMAX));
    end
    chk("sat.state", 32'(mon_state), 32'd0);
    // Clear ignores the edit and recovery on its own tick.
    tick(0,1,1,0,0,0,2'd3);
    chk("clr.edit_pulse", 32'(edit_pulse), 32'd0);
    chk("clr.edit_count", 32'(edit_count), 32'd0);
    chk("clr.rec_count", 32'(recovery_count), 32'd0);
    // Statistics keep counting inside VIOL.
    tick(0,0,0,1,0,1,2'd1);
    tick(0,0,1,1,0,1,2'd1);
    chk("viol.state", 32'(mon_state), 32'd2);
    chk("viol.edit_count", 32'(edit_count), 32'd1);
    chk("viol.rec_count", 32'(recovery_count), 32'd2);

    // Randomized run against the reference model.
    tick(1,0,0,0,0,0,2'd0);
    m_t = 0; m_atick = 0; model_step(1,0,0,0,0,0,0);
    for (int n = 0; n < 3000; n++) begin
      bit r, c, ai, bi, af, bf;
      int rc;
      r  = ($urandom_range(199) == 0);
      c  = ($urandom_range(29) == 0);
      af = ($urandom_range(5) == 0);
      bf = ($urandom_range(3) == 0);
      ai = af ^ ($urandom_range(7) == 0);
      bi = bf ^ ($urandom_range(7) == 0);
      rc = ($urandom_range(3) == 0) ? int'($urandom_range(3)) : 0;
      tick(r, c, ai, bi, af, bf, 2'(rc));
      model_step(r, c, ai, bi, af, bf, rc);
      chk_fsm($sformatf("rnd%0d", n), m_code != 0 ? 2'd2 : (m_pending ? 2'd1 : 2'd0),
              2'(m_code), 4'(m_wc));
      chk($sformatf("rnd%0d.edit_pulse", n), 32'(edit_pulse), 32'(m_pulse));
      chk($sformatf("rnd%0d.edit_count", n), 32'(edit_count), 32'(m_edits < CMAX ? m_edits : CMAX));
      chk($sformatf("rnd%0d.rec_count", n), 32'(recovery_count), 32'(m_recs < CMAX ? m_recs : CMAX));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
